// File: rtl/sp_ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_fifo_pkg
// Brief    : Width helpers and head-register state encoding for sp_ram_fifo.
// Revision : 1.0
// ============================================================================
package sp_ram_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // HEAD_WAIT: a refill read was issued last cycle and its data lands now
    localparam logic [1:0] HEAD_EMPTY = 2'd0;
    localparam logic [1:0] HEAD_WAIT  = 2'd1;
    localparam logic [1:0] HEAD_VALID = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sp_ram_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_fifo
// Brief    : Show-ahead FIFO controller over one external single-port RAM with
//            1-cycle read latency; a head register adds one entry of capacity.
//            Optional sticky overflow/underflow flags: SP_RAM_FIFO_ERR_EN.
// Revision : 1.0
// ============================================================================
module sp_ram_fifo
    import sp_ram_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            din,
    input  logic                        wput,
    output logic                        full,
    output logic [WIDTH-1:0]            dout,
    input  logic                        rget,
    output logic                        empty,
    output logic [ptr_width(DEPTH)-1:0] ram_address,
    output logic [WIDTH-1:0]            ram_write_data,
    output logic                        ram_write_en,
    input  logic [WIDTH-1:0]            ram_read_data
`ifdef SP_RAM_FIFO_ERR_EN
    ,
    output logic                        overflow,
    output logic                        underflow
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam int OW = CW + 1;
    localparam logic [OW-1:0] C_CAPACITY = OW'(DEPTH + 1);

    logic [1:0]       r_state,     w_state_n;
    logic [WIDTH-1:0] r_head,      w_head_n;
    logic [PW-1:0]    r_rd_ptr,    w_rd_ptr_n;
    logic [PW-1:0]    r_wr_ptr,    w_wr_ptr_n;
    logic [CW-1:0]    r_ram_count, w_count_n;
    logic             r_empty,     w_empty_n;
    logic             r_full,      w_full_n;
    logic             r_refill,    w_refill_n;
    logic [OW-1:0]    w_occ_n;

    logic w_push_ok, w_pop_ok, w_bypass, w_store, w_inflight, w_head_valid;

    assign w_inflight   = (r_state == HEAD_WAIT);
    assign w_head_valid = (r_state == HEAD_VALID);
    assign w_push_ok    = wput && !r_full;
    assign w_pop_ok     = rget && !r_empty;
    assign w_bypass     = (r_ram_count == '0) && !w_inflight && (!w_head_valid || w_pop_ok);
    assign w_store      = w_push_ok && !w_bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HEAD_EMPTY;
            r_head      <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_ram_count <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_refill    <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_head      <= w_head_n;
            r_rd_ptr    <= w_rd_ptr_n;
            r_wr_ptr    <= w_wr_ptr_n;
            r_ram_count <= w_count_n;
            r_empty     <= w_empty_n;
            r_full      <= w_full_n;
            r_refill    <= w_refill_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_head_n   = r_head;
        w_rd_ptr_n = r_rd_ptr;
        w_wr_ptr_n = r_wr_ptr;
        w_count_n  = r_ram_count;

        // A pending refill keeps full high, so it never competes with a store
        if (r_refill) begin
            w_rd_ptr_n = r_rd_ptr + PW'(1);
            w_count_n  = r_ram_count - CW'(1);
            w_state_n  = HEAD_WAIT;
        end else if (w_store) begin
            w_wr_ptr_n = r_wr_ptr + PW'(1);
            w_count_n  = r_ram_count + CW'(1);
        end

        case (r_state)
            HEAD_WAIT: begin
                w_head_n  = ram_read_data;
                w_state_n = HEAD_VALID;
            end
            HEAD_VALID: begin
                if (w_pop_ok) begin
                    if (w_push_ok && w_bypass) begin
                        w_head_n = din;
                    end else begin
                        w_state_n = HEAD_EMPTY;
                    end
                end
            end
            default: begin
                if (w_push_ok && w_bypass) begin
                    w_head_n  = din;
                    w_state_n = HEAD_VALID;
                end
            end
        endcase

        // Flags are derived from next state so they register alongside it
        w_occ_n    = OW'(w_state_n == HEAD_VALID) + OW'(w_state_n == HEAD_WAIT) + OW'(w_count_n);
        w_refill_n = (w_state_n == HEAD_EMPTY) && (w_count_n != '0);
        w_full_n   = (w_occ_n == C_CAPACITY) || w_refill_n;
        w_empty_n  = (w_state_n != HEAD_VALID);
    end

    always_comb begin
        ram_address    = r_rd_ptr;
        ram_write_data = din;
        ram_write_en   = 1'b0;
        if (w_store && !rst) begin
            ram_address  = r_wr_ptr;
            ram_write_en = 1'b1;
        end
    end

    assign full  = r_full;
    assign empty = r_empty;
    assign dout  = r_head;

`ifdef SP_RAM_FIFO_ERR_EN
    logic r_overflow, r_underflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wput && r_full && !r_refill) begin
                r_overflow <= 1'b1;
            end
            if (rget && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_fifo
// Brief    : Scoreboard bench for sp_ram_fifo (WIDTH=8, DEPTH=4) with a
//            1-cycle-latency single-port RAM model attached.
// Revision : 1.0
// ============================================================================
module tb_sp_ram_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic             wput;
    logic             full;
    logic [WIDTH-1:0] dout;
    logic             rget;
    logic             empty;
    logic [1:0]       ram_address;
    logic [WIDTH-1:0] ram_write_data;
    logic             ram_write_en;
    logic [WIDTH-1:0] ram_read_data;
`ifdef SP_RAM_FIFO_ERR_EN
    logic             overflow;
    logic             underflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_reads  = 0;

    logic [31:0] exp_q [$];   // expected pop data, in order
    logic [31:0] wq    [$];   // expected RAM writes {addr, data}
    logic [31:0] rq    [$];   // expected refill read addresses

    logic [WIDTH-1:0] mem [DEPTH];

    sp_ram_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .din            (din),
        .wput           (wput),
        .full           (full),
        .dout           (dout),
        .rget           (rget),
        .empty          (empty),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_write_en   (ram_write_en),
        .ram_read_data  (ram_read_data)
`ifdef SP_RAM_FIFO_ERR_EN
        ,
        .overflow       (overflow),
        .underflow      (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_address] <= ram_write_data;
        ram_read_data <= mem[ram_address];
    end

    function automatic logic [31:0] pack(input logic [1:0] a, input logic [7:0] d);
        return {22'd0, a, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_missing(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected / bound expired", name);
    endtask

    // Output monitor: compares every accepted pop against the scoreboard
    always @(negedge clk) begin
        if (!rst && rget && !empty) begin
            if (exp_q.size() == 0) report_missing("pop_unexpected");
            else check("pop_data", 32'(dout), exp_q.pop_front());
        end
    end

    // RAM port monitor: a refill cycle is visible as full && empty
    always @(negedge clk) begin
        if (rst) begin
            check("we_in_reset", 32'(ram_write_en), 32'd0);
        end else if (ram_write_en) begin
            if (wq.size() == 0) report_missing("ram_write_unexpected");
            else check("ram_write", pack(ram_address, ram_write_data), wq.pop_front());
        end else if (full && empty) begin
            n_reads++;
            if (rq.size() == 0) report_missing("ram_read_unexpected");
            else check("ram_read_addr", 32'(ram_address), rq.pop_front());
        end
    end

    task automatic push(input logic [7:0] d, input bit accept);
        check("full_at_push", 32'(full), 32'(!accept));
        wput = 1'b1;
        din  = d;
        if (accept) exp_q.push_back(32'(d));
        @(posedge clk); #2;
        wput = 1'b0;
    endtask

    task automatic pop_one();
        int n = 0;
        while (empty && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (empty) report_missing("pop_wait_timeout");
        rget = 1'b1;
        @(posedge clk); #2;
        rget = 1'b0;
    endtask

    task automatic wait_not_full();
        int n = 0;
        while (full && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (full) report_missing("full_wait_timeout");
    endtask

    task automatic drain();
        int n = 0;
        rget = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        rget = 1'b0;
        if (exp_q.size() != 0) report_missing("drain_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads_before;
        rst  = 1'b1;
        wput = 1'b0;
        rget = 1'b0;
        din  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full",  32'(full),  32'd0);
        check("reset_dout",  32'(dout),  32'd0);
`ifdef SP_RAM_FIFO_ERR_EN
        check("reset_overflow",  32'(overflow),  32'd0);
        check("reset_underflow", 32'(underflow), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #2;

        // Single word takes the bypass path into the head
        push(8'hA5, 1'b1);
        check("bypass_dout",  32'(dout),  32'hA5);
        check("bypass_empty", 32'(empty), 32'd0);
        pop_one();
        check("single_pop_empty", 32'(empty), 32'd1);

        // Fill: head + 4 RAM entries, then one refused push
        for (int i = 0; i < 4; i++) wq.push_back(pack(2'(i), 8'(i + 2)));
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
        check("fill_full", 32'(full), 32'd1);
        push(8'h06, 1'b0);
        check("fill_writes_done", 32'(wq.size()), 32'd0);
`ifdef SP_RAM_FIFO_ERR_EN
        check("overflow_set", 32'(overflow), 32'd1);
`endif

        // Drain through four refills
        for (int i = 0; i < 4; i++) rq.push_back(32'(i));
        reads_before = n_reads;
        drain();
        check("drain_refill_count", 32'(n_reads - reads_before), 32'd4);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_full",  32'(full),  32'd0);
        rget = 1'b1;
        @(posedge clk); #2;
        rget = 1'b0;
        check("rget_empty_still_empty", 32'(empty), 32'd1);
        check("rget_empty_full",        32'(full),  32'd0);
`ifdef SP_RAM_FIFO_ERR_EN
        check("underflow_set", 32'(underflow), 32'd1);
`endif

        // Interleaved traffic; addresses wrap past DEPTH-1
        for (int i = 0; i < 11; i++) rq.push_back(32'(i % 4));
        push(8'h30, 1'b1);
        wq.push_back(pack(2'd0, 8'h31));
        push(8'h31, 1'b1);
        for (int k = 2; k < 12; k++) begin
            wait_not_full();
            wq.push_back(pack(2'((k - 1) % 4), 8'(8'h30 + k)));
            push(8'(8'h30 + k), 1'b1);
            pop_one();
        end
        drain();
        check("wrap_reads_done",  32'(rq.size()), 32'd0);
        check("wrap_writes_done", 32'(wq.size()), 32'd0);

        // Reset lands while a refill read is in flight (pointers sit at 3)
        push(8'h11, 1'b1);
        wq.push_back(pack(2'd3, 8'h22));
        push(8'h22, 1'b1);
        rq.push_back(32'd3);
        pop_one();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        check("midreset_empty", 32'(empty), 32'd1);
        check("midreset_dout",  32'(dout),  32'd0);
        check("midreset_full",  32'(full),  32'd0);
        check("midreset_read_issued", 32'(rq.size()), 32'd0);
`ifdef SP_RAM_FIFO_ERR_EN
        check("midreset_underflow", 32'(underflow), 32'd0);
        check("midreset_overflow",  32'(overflow),  32'd0);
`endif

        // Pointers restart from zero after reset
        push(8'h5A, 1'b1);
        wq.push_back(pack(2'd0, 8'h5B));
        push(8'h5B, 1'b1);
        rq.push_back(32'd0);
        drain();
        @(posedge clk); #2;
        check("final_empty", 32'(empty), 32'd1);
        check("final_exp_q", 32'(exp_q.size()), 32'd0);
        check("final_wq",    32'(wq.size()),    32'd0);
        check("final_rq",    32'(rq.size()),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
